// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master, one-slave round-robin arbiter for the native
// memory bus, with a watchdog that terminates transactions the slave never
// acknowledges.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mX_valid/instr/addr/       master X request (X = 0 CPU, 1 debug/DMA)
//   wdata/wstrb
//   mX_ready/rdata/err         master X completion (combinational)
//   s_valid/instr/addr/        request to the address decoder, muxed from
//   wdata/wstrb                the granted master (combinational)
//   s_ready, s_rdata           slave completion and read data
//   grant                      one-hot current owner, 00 when idle
//   timeout                    one-cycle pulse when the watchdog fires
`timescale 1ns/1ps

module soc_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    input  logic                m0_instr,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_valid,
    input  logic                m1_instr,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_valid,
    output logic                s_instr,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant,
    output logic                timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 32'd2) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
    localparam bit          WD_EN = (TIMEOUT != 32'd0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    logic              busy;
    logic              sel;
    logic              mv;
    logic              done;
    logic              wd_fire;
    logic [DATA_W-1:0] rdata_c;

    // Decode of the current owner and its completion/termination conditions.
    always_comb begin
        busy    = (state_q != IDLE);
        sel     = (state_q == BUSY1);
        mv      = sel ? m1_valid : m0_valid;
        done    = busy && mv && s_ready;
        // A slave ready in the expiry cycle wins, so the watchdog only fires without it.
        wd_fire = WD_EN && busy && mv && !s_ready && (cnt_q == CNT_W'(TIMEOUT));
    end

    // Slave-side mux and master-side completion steering.
    always_comb begin
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        rdata_c  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m0_err   = 1'b0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        m1_err   = 1'b0;
        grant    = {state_q == BUSY1, state_q == BUSY0};
        timeout  = wd_fire;

        if (busy) begin
            s_valid = mv && !wd_fire;
            s_instr = sel ? m1_instr : m0_instr;
            s_addr  = sel ? m1_addr  : m0_addr;
            s_wdata = sel ? m1_wdata : m0_wdata;
            s_wstrb = sel ? m1_wstrb : m0_wstrb;
        end

        if (done) begin
            rdata_c = s_rdata;
        end else if (wd_fire) begin
            rdata_c = {DATA_W{1'b1}};
        end

        if (sel) begin
            m1_ready = done || wd_fire;
            m1_rdata = rdata_c;
            m1_err   = wd_fire;
        end else begin
            m0_ready = done || wd_fire;
            m0_rdata = rdata_c;
            m0_err   = wd_fire;
        end
    end

    // Arbitration FSM, round-robin history and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    // On a tie, the master that was not served last wins.
                    if (m0_valid && (!m1_valid || last_q)) begin
                        state_q <= BUSY0;
                    end else if (m1_valid) begin
                        state_q <= BUSY1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (!mv) begin
                        // Master withdrew its request: abandon without touching history.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (done || wd_fire) begin
                        state_q <= IDLE;
                        last_q  <= sel;
                        cnt_q   <= '0;
                    end else if (WD_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb_soc_bus_arbiter: scenario tasks for soc_bus_arbiter with a scoreboard of
// expected completions (owner, read data, error flag).
`timescale 1ns/1ps

module tb_soc_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic          mst;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          m0_valid, m0_instr, m0_ready, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [SW-1:0] m0_wstrb;
    logic          m1_valid, m1_instr, m1_ready, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [SW-1:0] m1_wstrb;
    logic          s_valid, s_instr, s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_wstrb;
    logic [1:0]    grant;
    logic          timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    soc_bus_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_valid(m0_valid),
        .m0_instr(m0_instr),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready),
        .m0_rdata(m0_rdata),
        .m0_err  (m0_err),
        .m1_valid(m1_valid),
        .m1_instr(m1_instr),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready),
        .m1_rdata(m1_rdata),
        .m1_err  (m1_err),
        .s_valid (s_valid),
        .s_instr (s_instr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .grant   (grant),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t observe();
        exp_t o;
        o.mst   = m1_ready;
        o.rdata = m1_ready ? m1_rdata : m0_rdata;
        o.err   = m1_ready ? m1_err : m0_err;
        return o;
    endfunction

    task automatic idle_inputs();
        m0_valid = 0; m0_instr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_instr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 0; s_rdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_checks++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
        n_checks++;
        if ({m0_ready, m1_ready, m0_err, m1_err, timeout} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {m0_ready, m1_ready, m0_err, m1_err, timeout});
        end
        n_checks++;
        if ({s_instr, s_addr, s_wdata, s_wstrb} !== '0) begin
            n_fail++; $display("FAIL reset_s_bus: got addr=%h wdata=%h wstrb=%b want zeros", s_addr, s_wdata, s_wstrb);
        end
        n_checks++;
        if ({m0_rdata, m1_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", m0_rdata, m1_rdata);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        exp_t e, o;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                m0_valid = 1; m0_instr = 1; m0_addr = 32'h0000_0010; m0_wstrb = '0;
                sb_q.push_back('{mst: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
            end
            if (c == 2) begin s_ready = 1; s_rdata = 32'hDEAD_BEEF; end
            if (c == 3) begin m0_valid = 0; m0_instr = 0; s_ready = 0; s_rdata = '0; end
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if ({s_valid, grant} !== 3'b000) begin n_fail++; $display("FAIL rd_c0_idle: got valid/grant=%b want 000", {s_valid, grant}); end
            end
            if (c == 1) begin
                n_checks++;
                if ({s_valid, grant, s_instr, m0_ready} !== 5'b10110) begin
                    n_fail++; $display("FAIL rd_c1_grant: got valid/grant/instr/rdy=%b want 10110", {s_valid, grant, s_instr, m0_ready});
                end
                n_checks++;
                if (s_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL rd_c1_addr: got %h want 00000010", s_addr); end
            end
            if (c == 2) begin
                n_checks++;
                if ({m0_ready, m1_ready} !== 2'b10) begin n_fail++; $display("FAIL rd_c2_ready: got m0/m1=%b want 10", {m0_ready, m1_ready}); end
            end
            if (m0_ready || m1_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_sb_underflow: got unexpected ready at cycle %0d", c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e) begin
                        n_fail++; $display("FAIL rd_sb: got mst=%0d rdata=%h err=%b want mst=%0d rdata=%h err=%b", o.mst, o.rdata, o.err, e.mst, e.rdata, e.err);
                    end
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({grant, m0_ready, m1_ready} !== 4'b0) begin n_fail++; $display("FAIL rd_c3_idle: got %b want 0000", {grant, m0_ready, m1_ready}); end
            end
            next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        exp_t e, o;
        int   served = 0;
        apply_reset();
        m0_valid = 1; m0_addr = 32'h0000_0100;
        m1_valid = 1; m1_addr = 32'h0000_0200;
        s_ready  = 1; s_rdata = 32'h5A5A_0000;
        for (int i = 0; i < 8; i++) sb_q.push_back('{mst: i[0], rdata: 32'h5A5A_0000, err: 1'b0});
        for (int c = 0; c < 24 && served < 8; c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                n_checks++;
                if (c != 1 + 2 * served) begin n_fail++; $display("FAIL rr_timing: got ready at cycle %0d want %0d", c, 1 + 2 * served); end
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL rr_sb_underflow: got extra ready at cycle %0d", c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e || {m1_ready, m0_ready} !== grant || grant !== {e.mst, ~e.mst}) begin
                        n_fail++; $display("FAIL rr_sb[%0d]: got grant=%b rdy=%b mst=%0d rdata=%h want mst=%0d rdata=%h", served, grant, {m1_ready, m0_ready}, o.mst, o.rdata, e.mst, e.rdata);
                    end
                end
                served++;
            end
            next_cycle();
        end
        n_checks++;
        if (served != 8) begin n_fail++; $display("FAIL rr_count: got %0d transactions want 8", served); end
        idle_inputs();
    endtask

    task automatic test_write_m1();
        exp_t e, o;
        int   ready_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                m1_valid = 1; m1_addr = 32'h0000_0025; m1_wdata = 32'h0000_0081; m1_wstrb = 4'b0001;
                sb_q.push_back('{mst: 1'b1, rdata: 32'h0, err: 1'b0});
            end
            if (c == 2) s_ready = 1;
            if (c == 3) begin m1_valid = 0; s_ready = 0; end
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if ({s_valid, grant, m1_ready} !== 4'b1100) begin n_fail++; $display("FAIL wr_c1_grant: got %b want 1100", {s_valid, grant, m1_ready}); end
                n_checks++;
                if ({s_addr, s_wdata, s_wstrb} !== {32'h0000_0025, 32'h0000_0081, 4'b0001}) begin
                    n_fail++; $display("FAIL wr_passthru: got addr=%h wdata=%h wstrb=%b want 00000025 00000081 0001", s_addr, s_wdata, s_wstrb);
                end
            end
            if (m0_ready || m1_ready) begin
                ready_cnt++;
                n_checks++;
                if (sb_q.size() == 0 || c != 2) begin
                    n_fail++; $display("FAIL wr_sb: got unexpected ready at cycle %0d", c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e) begin
                        n_fail++; $display("FAIL wr_sb: got mst=%0d rdata=%h err=%b want mst=%0d rdata=%h err=%b", o.mst, o.rdata, o.err, e.mst, e.rdata, e.err);
                    end
                end
            end
            next_cycle();
        end
        n_checks++;
        if (ready_cnt != 1) begin n_fail++; $display("FAIL wr_ready_pulses: got %0d want 1", ready_cnt); end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        exp_t e, o;
        // Part 1: slave never answers.
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                m0_valid = 1; m0_addr = 32'h0000_0300;
                sb_q.push_back('{mst: 1'b0, rdata: 32'hFFFF_FFFF, err: 1'b1});
            end
            if (c == 6) m0_valid = 0;
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if ({s_valid, m0_ready, timeout} !== 3'b100) begin n_fail++; $display("FAIL wd_wait_c%0d: got valid/rdy/to=%b want 100", c, {s_valid, m0_ready, timeout}); end
            end
            if (c == 5) begin
                n_checks++;
                if ({s_valid, timeout, m0_ready} !== 3'b011) begin n_fail++; $display("FAIL wd_fire: got valid/to/rdy=%b want 011", {s_valid, timeout, m0_ready}); end
            end
            if (m0_ready || m1_ready) begin
                n_checks++;
                if (sb_q.size() == 0 || c != 5) begin
                    n_fail++; $display("FAIL wd_sb: got unexpected ready at cycle %0d", c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e) begin
                        n_fail++; $display("FAIL wd_sb: got mst=%0d rdata=%h err=%b want mst=%0d rdata=%h err=%b", o.mst, o.rdata, o.err, e.mst, e.rdata, e.err);
                    end
                end
            end
            if (c == 6) begin
                n_checks++;
                if (grant !== 2'b00) begin n_fail++; $display("FAIL wd_idle_after: got grant=%b want 00", grant); end
            end
            next_cycle();
        end
        // Part 2: slave answers in the expiry cycle, normal completion wins.
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                m0_valid = 1;
                sb_q.push_back('{mst: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
            end
            if (c == 5) begin s_ready = 1; s_rdata = 32'h0BAD_F00D; end
            if (c == 6) begin m0_valid = 0; s_ready = 0; s_rdata = '0; end
            @(negedge clk);
            if (c == 5) begin
                n_checks++;
                if ({timeout, m0_ready, s_valid} !== 3'b011) begin n_fail++; $display("FAIL wd_race: got to/rdy/valid=%b want 011", {timeout, m0_ready, s_valid}); end
            end
            if (m0_ready || m1_ready) begin
                n_checks++;
                if (sb_q.size() == 0 || c != 5) begin
                    n_fail++; $display("FAIL wd_race_sb: got unexpected ready at cycle %0d", c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e) begin
                        n_fail++; $display("FAIL wd_race_sb: got mst=%0d rdata=%h err=%b want mst=%0d rdata=%h err=%b", o.mst, o.rdata, o.err, e.mst, e.rdata, e.err);
                    end
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        int   early_m1 = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin m1_valid = 1; m1_addr = 32'h0000_0044; end
            if (c == 2) rst = 1;
            if (c == 3) begin
                rst = 0; m0_valid = 1; m0_addr = 32'h0000_0048;
                sb_q.push_back('{mst: 1'b0, rdata: 32'h1111_2222, err: 1'b0});
            end
            if (c == 5) begin s_ready = 1; s_rdata = 32'h1111_2222; end
            if (c == 6) begin
                m0_valid = 0; s_ready = 0;
                sb_q.push_back('{mst: 1'b1, rdata: 32'h3333_4444, err: 1'b0});
            end
            if (c == 7) begin s_ready = 1; s_rdata = 32'h3333_4444; end
            if (c == 8) begin m1_valid = 0; s_ready = 0; s_rdata = '0; end
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (grant !== 2'b10) begin n_fail++; $display("FAIL rm_grant_m1: got %b want 10", grant); end
            end
            if (c == 3) begin
                n_checks++;
                if ({grant, s_valid, m0_ready, m1_ready, m0_err, m1_err, timeout, s_addr, m1_rdata} !== '0) begin
                    n_fail++; $display("FAIL rm_outputs_zero: got grant=%b valid=%b rdy=%b%b to=%b addr=%h", grant, s_valid, m0_ready, m1_ready, timeout, s_addr);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL rm_tie_after_reset: got grant=%b want 01", grant); end
            end
            if (m1_ready && c < 7) early_m1++;
            if (m0_ready || m1_ready) begin
                n_checks++;
                if (sb_q.size() == 0 || !(c == 5 || c == 7)) begin
                    n_fail++; $display("FAIL rm_sb: got unexpected ready m0=%b m1=%b at cycle %0d", m0_ready, m1_ready, c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e) begin
                        n_fail++; $display("FAIL rm_sb: got mst=%0d rdata=%h err=%b want mst=%0d rdata=%h err=%b", o.mst, o.rdata, o.err, e.mst, e.rdata, e.err);
                    end
                end
            end
            next_cycle();
        end
        n_checks++;
        if (early_m1 != 0) begin n_fail++; $display("FAIL rm_abandoned_ready: got %0d m1 ready pulses want 0", early_m1); end
        idle_inputs();
    endtask

    task automatic test_valid_withdraw();
        exp_t e, o;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin m0_valid = 1; m0_addr = 32'h0000_0500; end
            if (c == 2) m0_valid = 0;
            if (c == 3) begin
                m0_valid = 1; m1_valid = 1;
                sb_q.push_back('{mst: 1'b0, rdata: 32'hCAFE_0001, err: 1'b0});
            end
            if (c == 4) begin s_ready = 1; s_rdata = 32'hCAFE_0001; end
            if (c == 5) begin m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = '0; end
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if ({s_valid, grant} !== 3'b101) begin n_fail++; $display("FAIL vw_grant: got %b want 101", {s_valid, grant}); end
            end
            if (c == 2) begin
                n_checks++;
                if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin n_fail++; $display("FAIL vw_drop: got valid/rdy=%b want 000", {s_valid, m0_ready, m1_ready}); end
            end
            if (c == 3) begin
                n_checks++;
                if (grant !== 2'b00) begin n_fail++; $display("FAIL vw_idle: got grant=%b want 00", grant); end
            end
            if (c == 4) begin
                n_checks++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL vw_last_kept: got grant=%b want 01", grant); end
            end
            if (m0_ready || m1_ready) begin
                n_checks++;
                if (sb_q.size() == 0 || c != 4) begin
                    n_fail++; $display("FAIL vw_sb: got unexpected ready at cycle %0d", c);
                end else begin
                    e = sb_q.pop_front(); o = observe();
                    if (o !== e) begin
                        n_fail++; $display("FAIL vw_sb: got mst=%0d rdata=%h err=%b want mst=%0d rdata=%h err=%b", o.mst, o.rdata, o.err, e.mst, e.rdata, e.err);
                    end
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_m1();
        test_watchdog();
        test_reset_mid();
        test_valid_withdraw();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending completions want 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
